// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} db_state_e;

    localparam int NUM_COLS = 4;

    // Indexed by {row, col}; row 0 is the top row, col 0 the leftmost column.
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: per-frame press/release debounce FSM producing the registered key outputs.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_i,
    input  logic       pressed_i,
    input  logic [3:0] code_i,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    db_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0] cand_q, cand_d;
    logic [3:0] key_code_q, key_code_d;
    logic key_valid_q, key_valid_d;
    logic key_held_q, key_held_d;
    logic accept;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        cnt_inc = cnt_q + CNT_ONE;
        if (frame_i) begin
            case (state_q)
                IDLE: if (pressed_i) begin
                    cand_d  = code_i;
                    cnt_d   = CNT_ONE;
                    accept  = CNT_DONE == CNT_ONE;
                    state_d = accept ? HELD : DB_PRESS;
                end
                DB_PRESS: if (pressed_i && code_i == cand_q) begin
                    cnt_d   = cnt_inc;
                    accept  = cnt_inc == CNT_DONE;
                    state_d = accept ? HELD : DB_PRESS;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                HELD: if (!pressed_i) begin
                    cnt_d   = CNT_ONE;
                    state_d = CNT_DONE == CNT_ONE ? IDLE : DB_RELEASE;
                end
                DB_RELEASE: if (pressed_i) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else begin
                    cnt_d   = cnt_inc;
                    state_d = cnt_inc == CNT_DONE ? IDLE : DB_RELEASE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Acceptance only ever happens with code_i equal to the candidate, so code_i is latched directly.
    always_comb begin
        key_valid_d = accept;
        key_code_d  = accept ? code_i : key_code_q;
        key_held_d  = (state_d == HELD) || (state_d == DB_RELEASE);
    end

    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;
    assign key_held_o  = key_held_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans the 4x4 PmodKYPD matrix, encodes the first hit per frame
// and debounces it into a registered key code with a one-cycle strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 100000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SW  = $clog2(SCAN_CYCLES);
    localparam int CIW = $clog2(NUM_COLS);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [CIW-1:0] COL_LAST = CIW'(NUM_COLS - 1);

    logic [3:0] row_s1_q, row_s2_q;
    logic [3:0] col_q, col_d;
    logic [CIW-1:0] col_idx_q, col_idx_d;
    logic [SW-1:0] slot_q, slot_d;
    logic hit_q, hit_d;
    logic [3:0] hit_code_q, hit_code_d;
    logic slot_last, any_low, frame_end, frame_pressed;
    logic [1:0] first_row;
    logic [3:0] col_code, frame_code;

    always_ff @(posedge clock) begin
        if (reset) begin
            row_s1_q   <= 4'hF;
            row_s2_q   <= 4'hF;
            col_q      <= 4'b1110;
            col_idx_q  <= '0;
            slot_q     <= '0;
            hit_q      <= 1'b0;
            hit_code_q <= '0;
        end else begin
            row_s1_q   <= row;
            row_s2_q   <= row_s1_q;
            col_q      <= col_d;
            col_idx_q  <= col_idx_d;
            slot_q     <= slot_d;
            hit_q      <= hit_d;
            hit_code_q <= hit_code_d;
        end
    end

    // Within a column the lowest-numbered active row wins.
    always_comb begin
        slot_last     = slot_q == SLOT_LAST;
        any_low       = ~&row_s2_q;
        first_row     = ~row_s2_q[0] ? 2'd0 : ~row_s2_q[1] ? 2'd1 : ~row_s2_q[2] ? 2'd2 : 2'd3;
        col_code      = KEYMAP[{first_row, col_idx_q}];
        frame_end     = slot_last && col_idx_q == COL_LAST;
        frame_pressed = hit_q | any_low;
        frame_code    = hit_q ? hit_code_q : col_code;
    end

    always_comb begin
        slot_d     = slot_last ? '0 : slot_q + SW'(1);
        col_idx_d  = slot_last ? col_idx_q + CIW'(1) : col_idx_q;
        col_d      = slot_last ? {col_q[2:0], col_q[3]} : col_q;
        hit_d      = frame_end ? 1'b0 : slot_last ? frame_pressed : hit_q;
        hit_code_d = (slot_last && !hit_q) ? col_code : hit_code_q;
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clock      (clock),
        .reset      (reset),
        .frame_i    (frame_end),
        .pressed_i  (frame_pressed),
        .code_i     (frame_code),
        .key_code_o (key_code),
        .key_valid_o(key_valid),
        .key_held_o (key_held)
    );

    assign col = col_q;

endmodule
